ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//   Multi-cycle RV32M execute unit beside the single-cycle ALU in the EX stage.
//   Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU at a time and computes it iteratively.
//   Holds ex_stall while busy, so the pipeline freezes until the result is presented for EX->MEM.
// PARAMETERS
//   XLEN   32   operand/result width; power of two >= 8
//   CNT_W  $clog2(XLEN)+1   iteration counter width (derived; do not override)
// PORTS
//   clk        in   1     clock
//   rst        in   1     synchronous active-high reset
//   rdy        in   1     global ready; low = freeze all state and outputs
//   flush      in   1     branch/jump kill; abandons the op in flight
//   in_valid   in   1     op valid from ID/EX
//   op         in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   src1       in   XLEN  rs1 value
//   src2       in   XLEN  rs2 value
//   rd_in      in   5     destination register
//   ex_stall   out  1     stall request to the pipeline control
//   out_valid  out  1     result valid (one cycle pulse)
//   result     out  XLEN  rd write data
//   rd_out     out  5     destination register for the result
// BEHAVIOUR
//   Reset: state=IDLE; ex_stall=0, out_valid=0, result=0, rd_out=0, counter=0.
//   rdy=0: no state, counter, or register changes; outputs hold.
//   FSM: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: in_valid=1 latches op, rd_in, |src1|, |src2|, and the result sign; counter <= XLEN; go to CALC.
//     Signedness follows op: MULHSU takes src1 signed, src2 unsigned; MULHU/DIVU/REMU take both unsigned.
//   CALC, multiply: shift-add, one multiplier bit per cycle, 2*XLEN product register.
//   CALC, divide: restoring divider, one quotient bit per cycle.
//   CALC exit: counter decrements each cycle; move to DONE when it reaches 0 (XLEN CALC cycles).
//   DONE: apply sign fixup, drive result/rd_out, out_valid=1 for exactly one cycle, return to IDLE.
//   Result selection:
//     MUL: low XLEN product bits. MULH/MULHSU/MULHU: high XLEN product bits.
//     DIV/DIVU: quotient. REM/REMU: remainder.
//   Sign fixup:
//     quotient negative iff operand signs differ (signed ops only).
//     remainder takes the dividend's sign.
//     product sign = XOR of the signs of the signed operands.
//   Latency: accepted at edge T -> out_valid high in cycle T+XLEN+1 (33 cycles at XLEN=32).
//   ex_stall = (IDLE & in_valid) | CALC; low in DONE so the pipeline advances with the result.
//   Special cases bypass CALC (IDLE -> DONE, out_valid at T+1):
//     divide by zero: quotient = all ones; remainder = src1.
//     signed overflow (src1 = 100..0, src2 = all ones, DIV/REM): quotient = src1; remainder = 0.
//   Flush:
//     in any state, the next state is IDLE, out_valid=0, and result/rd_out hold.
//     flush together with in_valid in IDLE: flush wins and the op is dropped.
//   rd_in=0: computed normally; rd_out=0 (the writeback stage discards it).
//   in_valid in CALC/DONE is ignored; the upstream is stalled by ex_stall.
//   out_valid and ex_stall are never both high.
// CONFIGURATION
//   FAST_MUL_EN defined:
//     multiplies use one combinational 2*XLEN multiply registered in IDLE.
//     IDLE -> DONE directly; MUL* latency = 1 cycle.
//     Divides are unchanged.
//   FAST_MUL_EN undefined: all ops iterate as above; no hard multiplier is inferred.
// TESTING
//   1. MUL 7 x -3 (XLEN=32)
//      -> out_valid at T+33, result=0xFFFFFFEB; ex_stall high cycles T..T+32.
//   2. MULH 0x80000000 x 0x80000000 -> 0x40000000.
//      MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
//      MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//   3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
//      DIVU 100/7 -> 14; REMU 100/7 -> 2.
//   4. DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
//      DIV 0x80000000/-1 -> 0x80000000; REM -> 0. All with out_valid at T+1.
//   5. Flush in CALC cycle 10 -> IDLE next cycle, no out_valid.
//      A new DIVU 9/3 then accepted -> 3 at +33.
//   6. rdy low 5 cycles mid-CALC -> result delayed exactly 5 cycles, value unchanged.
//      rst mid-CALC -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Operand/result bundle between the ID/EX stage and the ex_muldiv execute unit.
interface ex_muldiv_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic [2:0]      op;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic [4:0]      rd_in;
   logic            ex_stall;
   logic            out_valid;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;

   modport master (
      output in_valid, op, src1, src2, rd_in,
      input  ex_stall, out_valid, result, rd_out
   );

   modport slave (
      input  in_valid, op, src1, src2, rd_in,
      output ex_stall, out_valid, result, rd_out
   );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit (shift-add multiplier, restoring divider) for the EX stage.
// Optional macro FAST_MUL_EN: multiplies use a single-cycle combinational multiplier.
module ex_muldiv #(
   parameter int XLEN = 32
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     rdy,
   input  logic     flush,
   ex_muldiv_if.slave bus
);
   localparam int CNT_W = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     b_q, b_d;
   logic [2:0]          op_q, op_d;
   logic [4:0]          rd_q, rd_d;
   logic                neg_q, neg_d;
   logic                out_valid_q, out_valid_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic [4:0]          rd_out_q, rd_out_d;

   logic                a_sgn, b_sgn, neg_in, div_zero, div_ovf;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic [XLEN:0]       mul_sum;
   logic [XLEN:0]       div_top;
   logic                div_ge;
   logic [XLEN-1:0]     div_sub;
   logic [2*XLEN-1:0]   step;
`ifdef FAST_MUL_EN
   logic [2*XLEN-1:0]   fast_prod;
`endif

   function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic neg);
      if (neg) begin
         return ~v + {{(XLEN-1){1'b0}}, 1'b1};
      end else begin
         return v;
      end
   endfunction

   // acc holds a magnitude product {hi,lo} or {remainder,quotient}; neg applies the sign.
   function automatic logic [XLEN-1:0] fixup(input logic [2*XLEN-1:0] acc,
                                             input logic [2:0] op, input logic neg);
      logic [2*XLEN-1:0] p;
      logic [XLEN-1:0]   q, r;
      p = neg ? (~acc + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc;
      q = abs_val(acc[XLEN-1:0], neg);
      r = abs_val(acc[2*XLEN-1:XLEN], neg);
      case (op)
         3'd0:             return p[XLEN-1:0];
         3'd1, 3'd2, 3'd3: return p[2*XLEN-1:XLEN];
         3'd4, 3'd5:       return q;
         3'd6, 3'd7:       return r;
         default:          return {XLEN{1'b0}};
      endcase
   endfunction

   assign bus.ex_stall  = ((state_q == IDLE) && bus.in_valid) || (state_q == CALC);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.rd_out    = rd_out_q;

   // Operand decode and one iteration of the shift-add / restoring-divide datapath.
   always_comb begin
      a_sgn    = ((bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6))
                 && bus.src1[XLEN-1];
      b_sgn    = ((bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6)) && bus.src2[XLEN-1];
      neg_in   = (bus.op == 3'd6) ? a_sgn : (a_sgn ^ b_sgn);
      a_mag    = abs_val(bus.src1, a_sgn);
      b_mag    = abs_val(bus.src2, b_sgn);
      div_zero = bus.op[2] && (bus.src2 == {XLEN{1'b0}});
      div_ovf  = ((bus.op == 3'd4) || (bus.op == 3'd6))
                 && (bus.src1 == {1'b1, {(XLEN-1){1'b0}}})
                 && (bus.src2 == {XLEN{1'b1}});
`ifdef FAST_MUL_EN
      fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif
      mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
      // Remainder stays below the divisor, so the shifted partial fits in XLEN+1 bits.
      div_top = acc_q[2*XLEN-1:XLEN-1];
      div_ge  = (div_top >= {1'b0, b_q});
      div_sub = div_top[XLEN-1:0] - b_q;
      step    = {2*XLEN{1'b0}};
      if (op_q[2]) begin
         if (div_ge) begin
            step = {div_sub, acc_q[XLEN-2:0], 1'b1};
         end else begin
            step = {div_top[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
         end
      end else begin
         step = {mul_sum, acc_q[XLEN-1:1]};
      end
   end

   // Next-state and next-output computation for the IDLE/CALC/DONE sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      b_d         = b_q;
      op_d        = op_q;
      rd_d        = rd_q;
      neg_d       = neg_q;
      out_valid_d = 1'b0;
      result_d    = result_q;
      rd_out_d    = rd_out_q;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = {CNT_W{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  op_d  = bus.op;
                  rd_d  = bus.rd_in;
                  neg_d = neg_in;
                  acc_d = {{XLEN{1'b0}}, a_mag};
                  b_d   = b_mag;
                  cnt_d = CNT_W'(XLEN);
                  if (div_zero) begin
                     state_d     = DONE;
                     cnt_d       = {CNT_W{1'b0}};
                     out_valid_d = 1'b1;
                     rd_out_d    = bus.rd_in;
                     result_d    = bus.op[1] ? bus.src1 : {XLEN{1'b1}};
                  end else if (div_ovf) begin
                     state_d     = DONE;
                     cnt_d       = {CNT_W{1'b0}};
                     out_valid_d = 1'b1;
                     rd_out_d    = bus.rd_in;
                     result_d    = bus.op[1] ? {XLEN{1'b0}} : bus.src1;
`ifdef FAST_MUL_EN
                  end else if (!bus.op[2]) begin
                     state_d     = DONE;
                     cnt_d       = {CNT_W{1'b0}};
                     out_valid_d = 1'b1;
                     rd_out_d    = bus.rd_in;
                     result_d    = fixup(fast_prod, bus.op, neg_in);
`endif
                  end else begin
                     state_d = CALC;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            CALC: begin
               cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
               acc_d = step;
               if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  result_d    = fixup(step, op_q, neg_q);
                  rd_out_d    = rd_q;
               end else begin
                  state_d = CALC;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers; rdy low freezes everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         acc_q       <= {2*XLEN{1'b0}};
         b_q         <= {XLEN{1'b0}};
         op_q        <= 3'd0;
         rd_q        <= 5'd0;
         neg_q       <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= {XLEN{1'b0}};
         rd_out_q    <= 5'd0;
      end else if (rdy) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         b_q         <= b_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         neg_q       <= neg_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         rd_out_q    <= rd_out_d;
      end
   end
endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized self-checking bench for ex_muldiv against an arithmetic RV32M reference model.
module tb_ex_muldiv;
   localparam int XLEN = 32;
`ifdef FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = XLEN + 1;
`endif

   logic clk = 1'b0;
   logic rst, rdy, flush;
   int   n_checks = 0;
   int   n_fail   = 0;

   ex_muldiv_if #(.XLEN(XLEN)) bus();

   ex_muldiv #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .rst   (rst),
      .rdy   (rdy),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // RISC-V M-extension semantics computed with wide integer arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
      longint     sa, sb, p;
      logic [63:0] ua, ub, pu;
      int         ia, ib;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'h0, a};
      ub = {32'h0, b};
      ia = a;
      ib = b;
      case (o)
         3'd0: begin p = sa * sb;  return p[31:0];  end
         3'd1: begin p = sa * sb;  return p[63:32]; end
         3'd2: begin p = sa * $signed(ub); return p[63:32]; end
         3'd3: begin pu = ua * ub; return pu[63:32]; end
         3'd4: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return ia / ib;
         end
         3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'h0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return ia % ib;
         end
         default: return (b == 32'h0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      if (!o[2]) return MUL_LAT;
      if (b == 32'h0) return 1;
      if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return $urandom_range(0, 20);
         default: return $urandom();
      endcase
   endfunction

   task automatic accept(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input string tag);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op       = o;
      bus.src1     = a;
      bus.src2     = b;
      bus.rd_in    = rd;
      #1 check({tag, ".stall_accept"}, {63'h0, bus.ex_stall}, 64'h1);
      @(posedge clk);
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input int rdy_at, input int rdy_len);
      int          n;
      bit          stall_ok;
      logic [31:0] exp;
      exp = ref_model(o, a, b);
      accept(o, a, b, rd, tag);
      n = 0;
      stall_ok = 1'b1;
      while (n < 200) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         n++;
         if (bus.out_valid) break;
         if (!bus.ex_stall) stall_ok = 1'b0;
         if (rdy_len > 0 && n == rdy_at) rdy = 1'b0;
         if (rdy_len > 0 && n == rdy_at + rdy_len) rdy = 1'b1;
      end
      rdy = 1'b1;
      check({tag, ".latency"}, 64'(n), 64'(exp_lat(o, a, b) + rdy_len));
      check({tag, ".result"}, {32'h0, bus.result}, {32'h0, exp});
      check({tag, ".rd_out"}, {59'h0, bus.rd_out}, {59'h0, rd});
      check({tag, ".stall_busy"}, {63'h0, stall_ok}, 64'h1);
      check({tag, ".stall_done"}, {63'h0, bus.ex_stall}, 64'h0);
      @(negedge clk);
      check({tag, ".pulse"}, {63'h0, bus.out_valid}, 64'h0);
   endtask

   task automatic watch_quiet(input string tag, input int cycles);
      bit quiet;
      quiet = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus.out_valid || bus.ex_stall) quiet = 1'b0;
      end
      check({tag, ".quiet"}, {63'h0, quiet}, 64'h1);
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; flush = 1'b0;
      bus.in_valid = 1'b0; bus.op = 3'd0; bus.src1 = 32'h0; bus.src2 = 32'h0; bus.rd_in = 5'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.stall", {63'h0, bus.ex_stall}, 64'h0);
      check("reset.valid", {63'h0, bus.out_valid}, 64'h0);
      check("reset.result", {32'h0, bus.result}, 64'h0);
      check("reset.rd", {59'h0, bus.rd_out}, 64'h0);
      rst = 1'b0;

      run_op("mul_7x-3",   3'd0, 32'd7,        32'hFFFF_FFFD, 5'd3,  0, 0);
      run_op("mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 0, 0);
      run_op("mulhsu",     3'd2, 32'hFFFF_FFFF, 32'd2,         5'd5, 0, 0);
      run_op("mulhu",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0, 0);
      run_op("div_-7/2",   3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7, 0, 0);
      run_op("rem_-7/2",   3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8, 0, 0);
      run_op("divu_100/7", 3'd5, 32'd100,      32'd7,          5'd9, 0, 0);
      run_op("remu_100/7", 3'd7, 32'd100,      32'd7,          5'd10, 0, 0);
      run_op("div_by0",    3'd4, 32'd5,        32'd0,          5'd11, 0, 0);
      run_op("rem_by0",    3'd6, 32'd5,        32'd0,          5'd12, 0, 0);
      run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, 0);
      run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0, 0);
      run_op("rd_zero",    3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 0, 0);

      // Flush in the tenth CALC cycle abandons the operation.
      accept(3'd5, 32'd1000, 32'd7, 5'd15, "flush");
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         if (i == 10) flush = 1'b1;
      end
      @(negedge clk);
      flush = 1'b0;
      check("flush.stall", {63'h0, bus.ex_stall}, 64'h0);
      check("flush.rd_hold", {59'h0, bus.rd_out}, 64'h0);
      watch_quiet("flush", 40);
      run_op("divu_9/3", 3'd5, 32'd9, 32'd3, 5'd16, 0, 0);

      // Flush together with in_valid in IDLE drops the operation.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.op = 3'd5; bus.src1 = 32'd50; bus.src2 = 32'd0; flush = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0; flush = 1'b0;
      watch_quiet("flush_idle", 40);

      run_op("rdy_hold", 3'd4, 32'hFFFF_FC00, 32'd9, 5'd17, 6, 5);

      // Reset in the middle of a calculation.
      accept(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd18, "rst");
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst.stall", {63'h0, bus.ex_stall}, 64'h0);
      check("rst.valid", {63'h0, bus.out_valid}, 64'h0);
      check("rst.result", {32'h0, bus.result}, 64'h0);
      check("rst.rd", {59'h0, bus.rd_out}, 64'h0);
      watch_quiet("rst", 40);

      for (int k = 0; k < 60; k++) begin
         logic [2:0]  o;
         logic [31:0] a, b;
         logic [4:0]  rd;
         o  = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         rd = 5'($urandom_range(0, 31));
         run_op($sformatf("rand%0d_op%0d", k, o), o, a, b, rd, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
